// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Brief    : Bit-serial adder controller. One full-adder cell is sequenced
//            across a WIDTH-bit operand pair, LSB first, with a carry flop.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   shift_a_q, shift_a_d;
    logic [WIDTH-1:0]   shift_b_q, shift_b_d;
    logic [WIDTH-1:0]   result_q,  result_d;
    logic               carry_q,   carry_d;
    logic               msb_cin_q, msb_cin_d;
    logic [c_cnt_w-1:0] cnt_q,     cnt_d;

    logic               w_fa_s;
    logic               w_fa_c;
    logic [WIDTH-1:0]   w_res_next;

    assign w_fa_s = shift_a_q[0] ^ shift_b_q[0] ^ carry_q;
    assign w_fa_c = (shift_a_q[0] & shift_b_q[0]) |
                    (shift_a_q[0] & carry_q)      |
                    (shift_b_q[0] & carry_q);

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_fa_s;
        end else begin : g_res_wn
            assign w_res_next = {w_fa_s, result_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        result_d  = result_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_a_d = a;
                    shift_b_d = b;
                    carry_d   = cin;
                    result_d  = '0;
                    cnt_d     = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d  = w_res_next;
                carry_d   = w_fa_c;
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                cnt_d     = cnt_q + c_cnt_w'(1);
                if (cnt_q == c_last_bit) begin
                    // Carry into the MSB cell, kept for the overflow flag.
                    msb_cin_d = carry_q;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign sum  = result_q;
    assign cout = carry_q;
    assign ovf  = msb_cin_q ^ carry_q;

endmodule
`default_nettype wire
